instr_mem_loader: RTL and testbench

Boot-time program loader that drives the instruction memory's write port (`instrWriteAddress`, `instrWriteData`, `instrWriteEnable`) from a byte stream. It receives a byte-wide valid/ready stream carrying a 16-bit word count followed by big-endian 16-bit instruction words. It writes those words to consecutive addresses and holds the processor in reset until the load completes. It sits beside the instruction memory at the top level, between the external boot link and the memory.

---
 rtl/instr_mem_loader_pkg.sv | 17 +
 rtl/instr_mem_loader.sv | 104 ++++++++++
 tb/tb_instr_mem_loader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    D_HI,
    D_LO,
    WRITE,
    DONE
  } loader_state_t;

  localparam int LOADER_HDR_BYTES      = 2;
  localparam int LOADER_BYTES_PER_WORD = 2;

endpackage

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: reads a 16-bit word count and big-endian words,
// writes them to consecutive instruction-memory addresses, holds the core in reset meanwhile.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W    = 20,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] instrWriteAddress,
  output logic [DATA_W-1:0] instrWriteData,
  output logic              instrWriteEnable,
  output logic              procReset,
  output logic              busy,
  output logic              done,
  output logic [15:0]       words_written
);

  loader_state_t state;
  loader_state_t nextState;
  logic [7:0]    hiByte;
  logic [15:0]   wordCount;
  logic [15:0]   writtenNext;
  logic          accept;

  assign accept      = in_valid && in_ready;
  assign writtenNext = words_written + 16'd1;

  // Next-state decode; in_ready is purely a function of state so upstream never sees a comb path
  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (start) nextState = CNT_HI;
      end
      CNT_HI: begin
        in_ready = 1'b1;
        if (in_valid) nextState = CNT_LO;
      end
      CNT_LO: begin
        in_ready = 1'b1;
        if (in_valid) nextState = ({hiByte, in_data} == 16'd0) ? DONE : D_HI;
      end
      D_HI: begin
        in_ready = 1'b1;
        if (in_valid) nextState = D_LO;
      end
      D_LO: begin
        in_ready = 1'b1;
        if (in_valid) nextState = WRITE;
      end
      WRITE: begin
        nextState = (writtenNext == wordCount) ? DONE : D_HI;
      end
      DONE: begin
        if (start) nextState = CNT_HI;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // The write port is loaded on the low-byte edge so it is stable throughout WRITE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hiByte            <= '0;
      wordCount         <= '0;
      words_written     <= '0;
      instrWriteAddress <= BASE_ADDR;
      instrWriteData    <= '0;
    end else begin
      if (accept && (state == CNT_HI || state == D_HI))
        hiByte <= in_data;
      if (accept && state == CNT_LO)
        wordCount <= {hiByte, in_data};
      if (accept && state == D_LO) begin
        instrWriteAddress <= BASE_ADDR + ADDR_W'(words_written);
        instrWriteData    <= DATA_W'({hiByte, in_data});
      end
      if (state == WRITE)
        words_written <= writtenNext;
      else if (start && (state == IDLE || state == DONE))
        words_written <= '0;
    end
  end

  assign instrWriteEnable = (state == WRITE);
  assign done             = (state == DONE);
  assign procReset        = (state != DONE);
  assign busy             = (state == CNT_HI) || (state == CNT_LO) || (state == D_HI) ||
                            (state == D_LO)   || (state == WRITE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a cycle table plus gapped, wrap and abort sequences.
module tb_instr_mem_loader;
  import loader_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        inValid;
  logic [7:0]  inData;

  logic        ready0, we0, pr0, busy0, done0;
  logic [19:0] addr0;
  logic [15:0] data0, ww0;
  logic        ready1, we1, pr1, busy1, done1;
  logic [19:0] addr1;
  logic [15:0] data1, ww1;

  int checks = 0;
  int errors = 0;

  logic [19:0] addr0Q[$];
  logic [15:0] data0Q[$];
  logic [19:0] addr1Q[$];
  logic [15:0] data1Q[$];
  logic        prevWe0 = 1'b0;

  always #5 clock = ~clock;

  instr_mem_loader #(.ADDR_W(20), .DATA_W(16), .BASE_ADDR(20'h00000)) dut (
    .clk(clock), .reset(reset), .start(start), .in_valid(inValid), .in_data(inData),
    .in_ready(ready0), .instrWriteAddress(addr0), .instrWriteData(data0),
    .instrWriteEnable(we0), .procReset(pr0), .busy(busy0), .done(done0),
    .words_written(ww0)
  );

  instr_mem_loader #(.ADDR_W(20), .DATA_W(16), .BASE_ADDR(20'hFFFFF)) dutWrap (
    .clk(clock), .reset(reset), .start(start), .in_valid(inValid), .in_data(inData),
    .in_ready(ready1), .instrWriteAddress(addr1), .instrWriteData(data1),
    .instrWriteEnable(we1), .procReset(pr1), .busy(busy1), .done(done1),
    .words_written(ww1)
  );

  // Record every write and police strobe shape on the base-0 instance
  always @(negedge clock) begin
    if (we0) begin
      addr0Q.push_back(addr0);
      data0Q.push_back(data0);
      checks++;
      if (ready0 !== 1'b0 || prevWe0 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL write_strobe in_ready=%b prev_we=%b required 0 0", ready0, prevWe0);
      end
    end
    if (we1) begin
      addr1Q.push_back(addr1);
      data1Q.push_back(data1);
    end
    prevWe0 = we0;
  end

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        we;
    logic        busy;
    logic        done;
    logic        pr;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] ww;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic s, logic v, logic [7:0] d, logic rdy, logic we,
                              logic bsy, logic dn, logic pr, logic [19:0] a,
                              logic [15:0] wd, logic [15:0] w);
    vec_t r;
    r.start = s; r.valid = v; r.data = d; r.ready = rdy; r.we = we; r.busy = bsy;
    r.done = dn; r.pr = pr; r.addr = a; r.wdata = wd; r.ww = w;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    start   = v.start;
    inValid = v.valid;
    inData  = v.data;
  endtask

  task automatic checkOutput(input int row, input vec_t v);
    logic [58:0] got, exp;
    got = {ready0, we0, busy0, done0, pr0, addr0, data0, ww0};
    exp = {v.ready, v.we, v.busy, v.done, v.pr, v.addr, v.wdata, v.ww};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL row%0d {rdy,we,busy,done,pr,addr,data,ww} got %h required %h",
               row, got, exp);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic doStart();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Offer one byte after a random idle gap and hold it until the loader takes it
  task automatic sendByte(input logic [7:0] b, input int maxGap);
    int gap;
    bit taken;
    gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
    inValid = 1'b0;
    for (int i = 0; i < gap; i++) @(negedge clock);
    inValid = 1'b1;
    inData  = b;
    taken   = 1'b0;
    for (int i = 0; i < 20 && !taken; i++) begin
      taken = ready0;
      @(negedge clock);
    end
    inValid = 1'b0;
    if (!taken) begin
      errors++;
      $display("[TB] FAIL byte_accept got not_taken required taken (byte %h)", b);
    end
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      seen = done0;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL wait_done got timeout required done=1");
    end
  endtask

  task automatic checkWrites(input string name, input logic [19:0] a0[$], input logic [15:0] d0[$],
                             input logic [19:0] ea[$], input logic [15:0] ed[$]);
    checkVal({name, "_count"}, 32'(a0.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < a0.size(); i++) begin
      checkVal($sformatf("%s_addr%0d", name, i), 32'(a0[i]), 32'(ea[i]));
      checkVal($sformatf("%s_data%0d", name, i), 32'(d0[i]), 32'(ed[i]));
    end
  endtask

  initial begin
    logic [7:0] stream[8];
    bit idleBad;

    vecs[0]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 20'h0, 16'h0000, 16'd0);
    vecs[1]  = mk(0, 1, 8'h00, 1, 0, 1, 0, 1, 20'h0, 16'h0000, 16'd0);
    vecs[2]  = mk(0, 1, 8'h03, 1, 0, 1, 0, 1, 20'h0, 16'h0000, 16'd0);
    vecs[3]  = mk(0, 1, 8'h12, 1, 0, 1, 0, 1, 20'h0, 16'h0000, 16'd0);
    vecs[4]  = mk(0, 1, 8'h34, 1, 0, 1, 0, 1, 20'h0, 16'h0000, 16'd0);
    vecs[5]  = mk(0, 1, 8'hAB, 0, 1, 1, 0, 1, 20'h0, 16'h1234, 16'd0);
    vecs[6]  = mk(0, 1, 8'hAB, 1, 0, 1, 0, 1, 20'h0, 16'h1234, 16'd1);
    vecs[7]  = mk(0, 1, 8'hCD, 1, 0, 1, 0, 1, 20'h0, 16'h1234, 16'd1);
    vecs[8]  = mk(0, 1, 8'h00, 0, 1, 1, 0, 1, 20'h1, 16'hABCD, 16'd1);
    vecs[9]  = mk(0, 1, 8'h00, 1, 0, 1, 0, 1, 20'h1, 16'hABCD, 16'd2);
    vecs[10] = mk(0, 1, 8'h01, 1, 0, 1, 0, 1, 20'h1, 16'hABCD, 16'd2);
    vecs[11] = mk(0, 0, 8'h00, 0, 1, 1, 0, 1, 20'h2, 16'h0001, 16'd2);
    vecs[12] = mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 20'h2, 16'h0001, 16'd3);
    vecs[13] = mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 20'h2, 16'h0001, 16'd3);
    vecs[14] = mk(0, 1, 8'h00, 1, 0, 1, 0, 1, 20'h2, 16'h0001, 16'd0);
    vecs[15] = mk(0, 1, 8'h00, 1, 0, 1, 0, 1, 20'h2, 16'h0001, 16'd0);
    vecs[16] = mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 20'h2, 16'h0001, 16'd0);

    stream = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};

    reset = 1'b1; start = 1'b0; inValid = 1'b0; inData = 8'h00;
    #12;
    checkVal("reset_outputs", {26'd0, ready0, we0, busy0, done0, pr0, (addr0 == 20'h0)},
             {26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    checkVal("reset_ww_data", {ww0, data0}, 32'h0);
    checkVal("reset_wrap_addr", 32'(addr1), 32'hFFFFF);
    @(negedge clock);
    reset = 1'b0;

    idleBad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (we0 || !pr0 || ready0) idleBad = 1'b1;
    end
    checkVal("idle_no_start", 32'(idleBad), 32'd0);

    $display("[TB] cycle table: N=3 ungapped load then N=0 load");
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      checkOutput(i, vecs[i]);
      applyStimulus(vecs[i]);
    end
    @(negedge clock);
    checkWrites("table", addr0Q, data0Q, '{20'h0, 20'h1, 20'h2}, '{16'h1234, 16'hABCD, 16'h0001});
    addr0Q.delete(); data0Q.delete(); addr1Q.delete(); data1Q.delete();

    $display("[TB] gapped N=3 load on both instances");
    doStart();
    foreach (stream[i]) sendByte(stream[i], 5);
    waitDone();
    checkVal("gapped_ww", 32'(ww0), 32'd3);
    checkVal("gapped_pr", 32'(pr0), 32'd0);
    checkWrites("gapped", addr0Q, data0Q, '{20'h0, 20'h1, 20'h2}, '{16'h1234, 16'hABCD, 16'h0001});
    checkWrites("wrap", addr1Q, data1Q, '{20'hFFFFF, 20'h00000, 20'h00001},
                '{16'h1234, 16'hABCD, 16'h0001});
    addr0Q.delete(); data0Q.delete(); addr1Q.delete(); data1Q.delete();

    $display("[TB] start while busy is ignored, then abort by reset");
    doStart();
    sendByte(8'h00, 0);
    sendByte(8'h03, 0);
    sendByte(8'h12, 0);
    start = 1'b1;
    sendByte(8'h34, 0);
    start = 1'b0;
    sendByte(8'hAB, 2);
    checkVal("busy_start_ignored", 32'(ww0), 32'd1);
    reset = 1'b1;
    #1;
    checkVal("abort_async", {29'd0, pr0, busy0, ready0}, {29'd0, 1'b1, 1'b0, 1'b0});
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    addr0Q.delete(); data0Q.delete(); addr1Q.delete(); data1Q.delete();
    inValid = 1'b1; inData = 8'hCD;
    for (int i = 0; i < 20; i++) @(negedge clock);
    inValid = 1'b0;
    checkVal("abort_no_writes", 32'(addr0Q.size()), 32'd0);
    checkVal("abort_state", 32'(dut.state), 32'(IDLE));
    checkVal("abort_outputs", {ww0, 11'd0, pr0, busy0, done0, ready0, we0},
             {16'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    doStart();
    sendByte(8'h00, 3);
    sendByte(8'h01, 3);
    sendByte(8'hBE, 3);
    sendByte(8'hEF, 3);
    waitDone();
    checkVal("reload_ww", 32'(ww0), 32'd1);
    checkWrites("reload", addr0Q, data0Q, '{20'h0}, '{16'hBEEF});
    checkWrites("reload_wrap", addr1Q, data1Q, '{20'hFFFFF}, '{16'hBEEF});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
